// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared cpu6 definitions used by the trap sequencer: datapath width,
// interrupt cause code and the trap FSM / event-kind encodings.
package cpu6_trap_ctrl_pkg;

  localparam int CPU6_XLEN      = 32;
  localparam int CPU6_IRQ_CAUSE = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/cpu6_trap_prio.sv
// Combinational event selector: picks exception > mret > enabled interrupt
// and forms the mepc/mcause candidates for the chosen event.
module cpu6_trap_prio
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN      = CPU6_XLEN,
  parameter int IRQ_CAUSE = CPU6_IRQ_CAUSE
) (
  input  logic            enable,
  input  logic            ex_excp_valid,
  input  logic [XLEN-1:0] ex_excp_pc,
  input  logic [3:0]      ex_excp_cause,
  input  logic            ex_mret,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mie_en,
  output logic            accept,
  output logic            is_mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] cause
);

  // NOTE: every output gets a default before the if-chain; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    accept  = 1'b0;
    is_mret = 1'b0;
    pc      = '0;
    cause   = '0;
    if (enable) begin
      if (ex_excp_valid) begin
        accept = 1'b1;
        pc     = ex_excp_pc;
        cause  = XLEN'(ex_excp_cause);
      end else if (ex_mret) begin
        accept  = 1'b1;
        is_mret = 1'b1;
      end else if (ext_irq && mie_en) begin
        accept = 1'b1;
        pc     = irq_pc;
        cause  = {1'b1, (XLEN-1)'(IRQ_CAUSE)};
      end
    end
  end

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// Trap sequencer: flushes and drains the pipeline, commits mepc/mcause,
// then hands fetch a redirect (mtvec for traps, mepc for mret).
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN      = CPU6_XLEN,
  parameter int IRQ_CAUSE = CPU6_IRQ_CAUSE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_excp_valid,
  input  logic [XLEN-1:0] ex_excp_pc,
  input  logic [3:0]      ex_excp_cause,
  input  logic            ex_mret,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            mie_en,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_rd,
  input  logic            pipe_idle,
  input  logic            csr_wr_en_in,
  output logic            csr_wr_en_out,
  output logic [XLEN-1:0] excp_mepc,
  output logic            excp_mepc_ena,
  output logic [XLEN-1:0] excp_mcause,
  output logic            excp_mcause_ena,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_ready,
  output logic            busy
);

  localparam logic [XLEN-1:0] HALF_ALIGN = ~XLEN'(1);
  localparam logic [XLEN-1:0] WORD_ALIGN = ~XLEN'(3);

  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q;
  logic [XLEN-1:0] pc_q, cause_q, target_q, target_d;
  logic            target_load;
  logic            in_idle;
  logic            accept, sel_mret;
  logic [XLEN-1:0] sel_pc, sel_cause;

  assign in_idle = (state_q == ST_IDLE);

  // Holding reset also masks acceptance so nothing flushes while in reset.
  cpu6_trap_prio #(
    .XLEN      (XLEN),
    .IRQ_CAUSE (IRQ_CAUSE)
  ) u_prio (
    .enable        (in_idle & reset),
    .ex_excp_valid (ex_excp_valid),
    .ex_excp_pc    (ex_excp_pc),
    .ex_excp_cause (ex_excp_cause),
    .ex_mret       (ex_mret),
    .ext_irq       (ext_irq),
    .irq_pc        (irq_pc),
    .mie_en        (mie_en),
    .accept        (accept),
    .is_mret       (sel_mret),
    .pc            (sel_pc),
    .cause         (sel_cause)
  );

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: only control/data registers here; all of them are reset so no
  // stale pc/cause can leak into a CSR write after an aborted sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_TRAP;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        kind_q  <= sel_mret ? KIND_MRET : KIND_TRAP;
        pc_q    <= sel_pc;
        cause_q <= sel_cause;
      end
      if (target_load) begin
        target_q <= target_d;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    target_load     = 1'b0;
    target_d        = '0;
    excp_mepc       = '0;
    excp_mepc_ena   = 1'b0;
    excp_mcause     = '0;
    excp_mcause_ena = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_idle) begin
          if (kind_q == KIND_MRET) begin
            target_load = 1'b1;
            target_d    = mepc_rd & HALF_ALIGN;
            state_d     = ST_REDIRECT;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        excp_mepc       = pc_q & HALF_ALIGN;
        excp_mepc_ena   = 1'b1;
        excp_mcause     = cause_q;
        excp_mcause_ena = 1'b1;
        // Direct mode only: the vectored-mode bits of mtvec are dropped.
        target_load     = 1'b1;
        target_d        = mtvec & WORD_ALIGN;
        state_d         = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (fetch_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush         = accept | (state_q == ST_DRAIN);
  assign busy          = ~in_idle;
  assign csr_wr_en_out = csr_wr_en_in & in_idle & ~accept;

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Self-checking bench: each event is expanded into an expected per-cycle
// timeline from its drain wait and fetch stall, and compared cycle by cycle.
module tb_cpu6_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_excp_valid, ex_mret, ext_irq, mie_en;
  logic [31:0] ex_excp_pc, irq_pc, mtvec, mepc_rd;
  logic [3:0]  ex_excp_cause;
  logic        pipe_idle, csr_wr_en_in, fetch_ready;
  logic        csr_wr_en_out, excp_mepc_ena, excp_mcause_ena;
  logic        flush, redirect_valid, busy;
  logic [31:0] excp_mepc, excp_mcause, redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu6_trap_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .ex_excp_valid   (ex_excp_valid),
    .ex_excp_pc      (ex_excp_pc),
    .ex_excp_cause   (ex_excp_cause),
    .ex_mret         (ex_mret),
    .ext_irq         (ext_irq),
    .irq_pc          (irq_pc),
    .mie_en          (mie_en),
    .mtvec           (mtvec),
    .mepc_rd         (mepc_rd),
    .pipe_idle       (pipe_idle),
    .csr_wr_en_in    (csr_wr_en_in),
    .csr_wr_en_out   (csr_wr_en_out),
    .excp_mepc       (excp_mepc),
    .excp_mepc_ena   (excp_mepc_ena),
    .excp_mcause     (excp_mcause),
    .excp_mcause_ena (excp_mcause_ena),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_ready     (fetch_ready),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_events();
    ex_excp_valid = 1'b0;
    ex_mret       = 1'b0;
    ext_irq       = 1'b0;
    mie_en        = 1'b0;
  endtask

  task automatic random_events();
    ex_excp_valid = 1'($urandom);
    ex_mret       = 1'($urandom);
    ext_irq       = 1'($urandom);
    mie_en        = 1'($urandom);
    ex_excp_pc    = $urandom;
    ex_excp_cause = 4'($urandom);
    irq_pc        = $urandom;
    csr_wr_en_in  = 1'($urandom);
  endtask

  // Compare one cycle's outputs at the falling edge, then advance to just
  // after the next rising edge where the caller drives new inputs.
  task automatic step(input string tag, input bit f, input bit b, input bit cm,
                      input logic [31:0] mepc_e, input logic [31:0] mcause_e,
                      input bit rv, input logic [31:0] rpc_e, input bit csr_e);
    @(negedge clk);
    check({tag, ".flush"}, 32'(flush), 32'(f));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".mepc_ena"}, 32'(excp_mepc_ena), 32'(cm));
    check({tag, ".mcause_ena"}, 32'(excp_mcause_ena), 32'(cm));
    check({tag, ".rvalid"}, 32'(redirect_valid), 32'(rv));
    check({tag, ".csr_wr"}, 32'(csr_wr_en_out), 32'(csr_e));
    if (cm) begin
      check({tag, ".mepc"}, excp_mepc, mepc_e);
      check({tag, ".mcause"}, excp_mcause, mcause_e);
    end
    if (rv) check({tag, ".rpc"}, redirect_pc, rpc_e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flush"}, 32'(flush), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".rvalid"}, 32'(redirect_valid), 32'd0);
    check({tag, ".enas"}, 32'({excp_mepc_ena, excp_mcause_ena}), 32'd0);
    check({tag, ".csr_wr"}, 32'(csr_wr_en_out), 32'd0);
    check({tag, ".mepc"}, excp_mepc, 32'd0);
    check({tag, ".mcause"}, excp_mcause, 32'd0);
    check({tag, ".rpc"}, redirect_pc, 32'd0);
  endtask

  // One event offered in IDLE. dw = cycles pipe_idle stays low in DRAIN,
  // st = cycles fetch_ready stays low in REDIRECT, abort = cycle index at
  // which reset is pulled (-1 for none). Cycle 0 is the accept cycle.
  task automatic txn(input string tag, input bit e, input bit m, input bit i, input bit mie,
                     input logic [31:0] epc, input logic [3:0] ecause, input logic [31:0] ipc,
                     input logic [31:0] tvec, input logic [31:0] mepc_v,
                     input int dw, input int st, input int abort, input bit csr0);
    bit          acc, is_mret, cm, rv;
    logic [31:0] exp_mepc, exp_cause, exp_tgt;
    int          r0, last;
    acc       = e | m | (i & mie);
    is_mret   = !e && m;
    exp_mepc  = e ? (epc & 32'hFFFF_FFFE) : (ipc & 32'hFFFF_FFFE);
    exp_cause = e ? {28'h0, ecause} : 32'h8000_000B;
    exp_tgt   = is_mret ? (mepc_v & 32'hFFFF_FFFE) : (tvec & 32'hFFFF_FFFC);
    r0        = is_mret ? dw + 2 : dw + 3;
    last      = r0 + st;

    ex_excp_valid = e;     ex_mret = m;    ext_irq = i;   mie_en = mie;
    ex_excp_pc    = epc;   ex_excp_cause = ecause;        irq_pc = ipc;
    mtvec         = tvec;  mepc_rd = mepc_v;
    csr_wr_en_in  = csr0;
    pipe_idle     = 1'($urandom);
    fetch_ready   = 1'($urandom);
    step($sformatf("%s.c0", tag), acc, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, csr0 & !acc);

    if (acc) begin
      for (int c = 1; c <= last; c++) begin
        random_events();
        pipe_idle   = (c <= dw) ? 1'b0 : (c == dw + 1) ? 1'b1 : 1'($urandom);
        fetch_ready = (c < r0) ? 1'($urandom) : (c == last);
        if (c == abort) begin
          reset = 1'b0;
          clear_events();
          csr_wr_en_in = 1'b0;
          #2;
          check_all_zero($sformatf("%s.rst%0d", tag, c));
          @(posedge clk);
          #1;
          reset = 1'b1;
          break;
        end
        cm = !is_mret && (c == dw + 2);
        rv = (c >= r0);
        step($sformatf("%s.c%0d", tag, c), c <= dw + 1, 1'b1, cm, exp_mepc, exp_cause,
             rv, exp_tgt, 1'b0);
      end
    end

    clear_events();
    csr_wr_en_in = 1'($urandom);
    step({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, csr_wr_en_in);
  endtask

  initial begin
    reset        = 1'b0;
    clear_events();
    ex_excp_pc   = '0;  ex_excp_cause = '0;  irq_pc  = '0;
    mtvec        = '0;  mepc_rd       = '0;
    pipe_idle    = 1'b0; csr_wr_en_in = 1'b0; fetch_ready = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    txn("excp_basic", 1, 0, 0, 0, 32'h0000_1004, 4'd2, 32'h0, 32'h0000_0103, 32'h0, 0, 0, -1, 1'b0);
    txn("irq",        0, 0, 1, 1, 32'h0, 4'd0, 32'h0000_2000, 32'h0000_0200, 32'h0, 0, 1, -1, 1'b0);
    txn("irq_masked", 0, 0, 1, 0, 32'h0, 4'd0, 32'h0000_2000, 32'h0000_0200, 32'h0, 0, 0, -1, 1'b1);
    txn("all_three",  1, 1, 1, 1, 32'h0000_4008, 4'd7, 32'h0000_5000, 32'h0000_0400, 32'h0, 2, 0, -1, 1'b0);
    txn("mret",       0, 1, 0, 0, 32'h0, 4'd0, 32'h0, 32'h0000_0100, 32'h0000_3001, 4, 0, -1, 1'b0);
    txn("stall",      1, 0, 0, 0, 32'h0000_6001, 4'd5, 32'h0, 32'h0000_0800, 32'h0, 0, 3, -1, 1'b0);
    txn("csr_race",   1, 0, 0, 0, 32'h0000_7000, 4'd11, 32'h0, 32'h0000_0900, 32'h0, 1, 0, -1, 1'b1);
    txn("rst_commit", 1, 0, 0, 0, 32'h0000_8000, 4'd3, 32'h0, 32'h0000_0A00, 32'h0, 0, 2, 2, 1'b0);
    txn("rst_redir",  0, 0, 1, 1, 32'h0, 4'd0, 32'h0000_9000, 32'h0000_0B00, 32'h0, 1, 3, 5, 1'b0);

    for (int n = 0; n < 80; n++) begin
      int dw, st, ab;
      dw = int'($urandom_range(0, 4));
      st = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : -1;
      txn($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom, 4'($urandom), $urandom, $urandom, $urandom, dw, st, ab, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
